// File: rtl/operand_stage.sv
// operand_stage
//   Decode/operand-fetch stage. Holds the register file and carry flag, and a
//   single-entry pipeline register that presents an instruction plus its four
//   operands and the carry to the ALU.
//
//   Ports
//     clk, rst_n            clock (rising edge), async active-low reset
//     in_valid/in_ready     upstream handshake, in_instruction = fetched word
//     out_valid/out_ready   downstream handshake toward ALU/writeback
//     instruction           registered instruction word
//     regA/regA_imm6/       operands RF[ins[5:3]], RF[ins[8:6]],
//     regA_imm8/regB          RF[ins[10:8]], RF[ins[2:0]]
//     carry                 carry flag captured with the instruction
//     wb_en/wb_addr/wb_data register writeback
//     wb_carry_en/wb_carry  carry flag writeback
//
//   Writebacks land in the RF regardless of handshake state. Operands are
//   bypassed at capture and refreshed while held, so the ALU never sees a
//   value older than the register file.

// One bypassed RF read port: returns wb_data when this cycle's writeback
// targets the same register, otherwise the stored entry.
module operand_rdport #(
  parameter int DATA_W  = 16,
  parameter int REG_CNT = 8
) (
  input  logic [REG_CNT-1:0][DATA_W-1:0] i_rf,
  input  logic [2:0]                     i_addr,
  input  logic                           i_wb_en,
  input  logic [2:0]                     i_wb_addr,
  input  logic [DATA_W-1:0]              i_wb_data,
  output logic [DATA_W-1:0]              o_data
);
  always_comb begin
    o_data = '0;
    if (32'(i_addr) < REG_CNT) o_data = i_rf[i_addr];
    if (i_wb_en && (i_addr == i_wb_addr)) o_data = i_wb_data;
  end
endmodule

module operand_stage #(
  parameter int DATA_W  = 16,
  parameter int REG_CNT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [15:0]       in_instruction,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       instruction,
  output logic [DATA_W-1:0] regA,
  output logic [DATA_W-1:0] regA_imm6,
  output logic [DATA_W-1:0] regA_imm8,
  output logic [DATA_W-1:0] regB,
  output logic              carry,
  input  logic              wb_en,
  input  logic [2:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              wb_carry_en,
  input  logic              wb_carry
);

  localparam int NUM_OPS = 4;

  // Operand slot order: 0 regA, 1 regA_imm6, 2 regA_imm8, 3 regB.
  function automatic logic [NUM_OPS-1:0][2:0] op_addrs(input logic [15:0] ins);
    logic [NUM_OPS-1:0][2:0] a;
    a[0] = ins[5:3];
    a[1] = ins[8:6];
    a[2] = ins[10:8];
    a[3] = ins[2:0];
    return a;
  endfunction

  logic [REG_CNT-1:0][DATA_W-1:0] r_rf;
  logic                           r_cflag;

  logic                           r_valid;
  logic [15:0]                    r_instr;
  logic [NUM_OPS-1:0][DATA_W-1:0] r_opnd;
  logic                           r_carry_out;

  logic [NUM_OPS-1:0][2:0]        w_cap_addr;
  logic [NUM_OPS-1:0][2:0]        w_held_addr;
  logic [NUM_OPS-1:0][DATA_W-1:0] w_cap_data;
  logic                           w_cap_carry;
  logic                           w_accept;
  logic                           w_hold;

  assign w_cap_addr  = op_addrs(in_instruction);
  assign w_held_addr = op_addrs(r_instr);
  assign w_cap_carry = wb_carry_en ? wb_carry : r_cflag;

  assign in_ready = !r_valid || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_hold   = r_valid && !out_ready;

  // Capture-side read ports, one per operand slot. Aliased fields read the
  // same entry through identical logic, so they always agree.
  for (genvar g = 0; g < NUM_OPS; g++) begin : g_rd
    operand_rdport #(.DATA_W(DATA_W), .REG_CNT(REG_CNT)) u_rd (
      .i_rf      (r_rf),
      .i_addr    (w_cap_addr[g]),
      .i_wb_en   (wb_en),
      .i_wb_addr (wb_addr),
      .i_wb_data (wb_data),
      .o_data    (w_cap_data[g])
    );
  end

  // Register file and carry flag: writeback is independent of the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rf    <= '0;
      r_cflag <= 1'b0;
    end else begin
      if (wb_en && (32'(wb_addr) < REG_CNT)) r_rf[wb_addr] <= wb_data;
      if (wb_carry_en) r_cflag <= wb_carry;
    end
  end

  // Single-entry pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_instr     <= '0;
      r_opnd      <= '0;
      r_carry_out <= 1'b0;
    end else if (w_accept) begin
      r_valid     <= 1'b1;
      r_instr     <= in_instruction;
      r_opnd      <= w_cap_data;
      r_carry_out <= w_cap_carry;
    end else if (w_hold) begin
      // Stalled: track writebacks so the held operands stay current.
      for (int i = 0; i < NUM_OPS; i++)
        if (wb_en && (w_held_addr[i] == wb_addr)) r_opnd[i] <= wb_data;
      if (wb_carry_en) r_carry_out <= wb_carry;
    end else if (r_valid) begin
      // Consumed with nothing behind it; data registers keep last values.
      r_valid <= 1'b0;
    end
  end

  assign out_valid   = r_valid;
  assign instruction = r_instr;
  assign regA        = r_opnd[0];
  assign regA_imm6   = r_opnd[1];
  assign regA_imm8   = r_opnd[2];
  assign regB        = r_opnd[3];
  assign carry       = r_carry_out;

endmodule

// File: tb/tb_operand_stage.sv
module tb_operand_stage;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [15:0]   in_instruction;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   instruction;
  logic [DW-1:0] regA, regA_imm6, regA_imm8, regB;
  logic          carry;
  logic          wb_en;
  logic [2:0]    wb_addr;
  logic [DW-1:0] wb_data;
  logic          wb_carry_en;
  logic          wb_carry;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  operand_stage #(.DATA_W(DW), .REG_CNT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_instruction(in_instruction), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .instruction(instruction),
    .regA(regA), .regA_imm6(regA_imm6), .regA_imm8(regA_imm8), .regB(regB),
    .carry(carry),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_carry_en(wb_carry_en), .wb_carry(wb_carry)
  );

  typedef struct {
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        wbc_en;
    logic        wbc;
    logic        iv;
    logic [15:0] ins;
    logic        ordy;
    logic        e_v;
    logic [15:0] e_ins, e_a, e_a6, e_a8, e_b;
    logic        e_c;
    logic        e_ir;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s[%0d] got %h want %h", nm, idx, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [15:0] ins, input logic ordy,
                       input logic we, input logic [2:0] wa, input logic [15:0] wd,
                       input logic ce, input logic cv);
    in_valid = iv; in_instruction = ins; out_ready = ordy;
    wb_en = we; wb_addr = wa; wb_data = wd; wb_carry_en = ce; wb_carry = cv;
  endtask

  task automatic chk_all(input string nm, input int idx, input logic v, input logic [15:0] ins,
                         input logic [15:0] a, input logic [15:0] a6, input logic [15:0] a8,
                         input logic [15:0] b, input logic c, input logic ir);
    chk({nm, ".out_valid"}, idx, 32'(out_valid), 32'(v));
    chk({nm, ".instruction"}, idx, 32'(instruction), 32'(ins));
    chk({nm, ".regA"}, idx, 32'(regA), 32'(a));
    chk({nm, ".regA_imm6"}, idx, 32'(regA_imm6), 32'(a6));
    chk({nm, ".regA_imm8"}, idx, 32'(regA_imm8), 32'(a8));
    chk({nm, ".regB"}, idx, 32'(regB), 32'(b));
    chk({nm, ".carry"}, idx, 32'(carry), 32'(c));
    chk({nm, ".in_ready"}, idx, 32'(in_ready), 32'(ir));
  endtask

  function automatic vec_t mkv(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                               input logic ce, input logic cv, input logic iv,
                               input logic [15:0] ins, input logic ordy, input logic ev,
                               input logic [15:0] eins, input logic [15:0] ea,
                               input logic [15:0] ea6, input logic [15:0] ea8,
                               input logic [15:0] eb, input logic ec, input logic eir);
    vec_t v;
    v.wb_en = we; v.wb_addr = wa; v.wb_data = wd; v.wbc_en = ce; v.wbc = cv;
    v.iv = iv; v.ins = ins; v.ordy = ordy;
    v.e_v = ev; v.e_ins = eins; v.e_a = ea; v.e_a6 = ea6; v.e_a8 = ea8;
    v.e_b = eb; v.e_c = ec; v.e_ir = eir;
    return v;
  endfunction

  initial begin
    // RF writes, ADD capture, bypass, 4-deep stream with carry traffic, drain.
    //           we wa wd        ce cv iv ins       rdy  v ins      A        A6       A8       B        c ir
    vt[0] = mkv(1, 1, 16'd10,    0, 0, 0, 16'h0000, 1,   0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 1);
    vt[1] = mkv(1, 2, 16'd5,     0, 0, 0, 16'h0000, 1,   0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 1);
    vt[2] = mkv(0, 0, 16'h0000,  0, 0, 1, 16'h8042, 1,   1, 16'h8042, 16'h0000, 16'd10,   16'h0000, 16'd5,    0, 1);
    vt[3] = mkv(1, 3, 16'h1234,  0, 0, 1, 16'h001B, 1,   1, 16'h001B, 16'h1234, 16'h0000, 16'h0000, 16'h1234, 0, 1);
    vt[4] = mkv(0, 0, 16'h0000,  1, 1, 1, 16'h0288, 1,   1, 16'h0288, 16'd10,   16'd5,    16'd5,    16'h0000, 1, 1);
    vt[5] = mkv(1, 0, 16'h00FF,  0, 0, 1, 16'h0011, 1,   1, 16'h0011, 16'd5,    16'h00FF, 16'h00FF, 16'd10,   1, 1);
    vt[6] = mkv(0, 0, 16'h0000,  1, 0, 1, 16'h0700, 1,   1, 16'h0700, 16'h00FF, 16'h0000, 16'h0000, 16'h00FF, 0, 1);
    vt[7] = mkv(0, 0, 16'h0000,  0, 0, 1, 16'h00C9, 1,   1, 16'h00C9, 16'd10,   16'h1234, 16'h00FF, 16'd10,   0, 1);
    vt[8] = mkv(0, 0, 16'h0000,  0, 0, 0, 16'h0000, 1,   0, 16'h00C9, 16'd10,   16'h1234, 16'h00FF, 16'd10,   0, 1);
    vt[9] = mkv(1, 5, 16'hABCD,  0, 0, 0, 16'h0000, 1,   0, 16'h00C9, 16'd10,   16'h1234, 16'h00FF, 16'd10,   0, 1);

    rst_n = 1'b0;
    drive(0, 16'h0, 1, 0, 0, 16'h0, 0, 0);
    tick(); tick();
    chk_all("reset", 0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 1);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      drive(vt[i].iv, vt[i].ins, vt[i].ordy, vt[i].wb_en, vt[i].wb_addr, vt[i].wb_data,
            vt[i].wbc_en, vt[i].wbc);
      tick();
      chk_all("vec", i, vt[i].e_v, vt[i].e_ins, vt[i].e_a, vt[i].e_a6, vt[i].e_a8,
              vt[i].e_b, vt[i].e_c, vt[i].e_ir);
    end

    // Hold: 0x0002 reads RF0 (0xFF) for A/A6/A8 and RF2 (5) for B.
    drive(1, 16'h0002, 0, 0, 0, 16'h0, 0, 0);
    tick();
    chk_all("hold", 0, 1, 16'h0002, 16'h00FF, 16'h00FF, 16'h00FF, 16'd5, 0, 0);
    // Competing instruction must be ignored; writeback to RF2 refreshes regB.
    drive(1, 16'hFFFF, 0, 1, 2, 16'd7, 0, 0);
    tick();
    chk_all("hold", 1, 1, 16'h0002, 16'h00FF, 16'h00FF, 16'h00FF, 16'd7, 0, 0);
    // Carry writeback refreshes the held carry.
    drive(1, 16'hFFFF, 0, 0, 0, 16'h0, 1, 1);
    tick();
    chk_all("hold", 2, 1, 16'h0002, 16'h00FF, 16'h00FF, 16'h00FF, 16'd7, 1, 0);

    // Async reset mid-hold, between clock edges.
    drive(1, 16'hFFFF, 0, 0, 0, 16'h0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 1);
    // Writeback and in_valid ignored while in reset.
    drive(1, 16'h0288, 1, 1, 1, 16'd99, 1, 1);
    tick();
    chk_all("async_rst", 1, 0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 1);

    // First edge after release accepts; RF1/RF2 must read back as cleared.
    rst_n = 1'b1;
    drive(1, 16'h0288, 1, 0, 0, 16'h0, 0, 0);
    tick();
    chk_all("post_rst", 0, 1, 16'h0288, 16'h0, 16'h0, 16'h0, 16'h0, 0, 1);
    drive(0, 16'h0, 1, 0, 0, 16'h0, 0, 0);
    tick();
    chk_all("post_rst", 1, 0, 16'h0288, 16'h0, 16'h0, 16'h0, 16'h0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
